// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit holding HI/LO
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by MDU_MADD_EN.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  count;
  logic [63:0] pend;
  logic        pend_wr;

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  logic        launch;
  logic        launch_wr;
  logic [3:0]  launch_n;
  logic [63:0] launch_res;

  always_comb begin
    mul_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    mul_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no special case.
    div_signed = (op == OP_DIV);
    a_mag = (div_signed && rs[31]) ? -rs : rs;
    b_mag = (div_signed && rt[31]) ? -rt : rt;
    q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    quot  = (div_signed && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
    rem   = (div_signed && rs[31]) ? -r_mag : r_mag;

    launch     = 1'b0;
    launch_wr  = 1'b0;
    launch_n   = 4'd0;
    launch_res = 64'd0;
    case (op)
      OP_MULT: begin
        launch = 1'b1; launch_wr = 1'b1; launch_n = MULT_N; launch_res = mul_s;
      end
      OP_MULTU: begin
        launch = 1'b1; launch_wr = 1'b1; launch_n = MULT_N; launch_res = mul_u;
      end
      OP_DIV, OP_DIVU: begin
        launch = 1'b1; launch_wr = (rt != 32'd0); launch_n = DIV_N;
        launch_res = {rem, quot};
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        launch = 1'b1; launch_wr = 1'b1; launch_n = MULT_N;
        launch_res = {hi, lo} + mul_s;
      end
      OP_MADDU: begin
        launch = 1'b1; launch_wr = 1'b1; launch_n = MULT_N;
        launch_res = {hi, lo} + mul_u;
      end
      OP_MSUB: begin
        launch = 1'b1; launch_wr = 1'b1; launch_n = MULT_N;
        launch_res = {hi, lo} - mul_s;
      end
      OP_MSUBU: begin
        launch = 1'b1; launch_wr = 1'b1; launch_n = MULT_N;
        launch_res = {hi, lo} - mul_u;
      end
`endif
      default: begin
        launch = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      busy    <= 1'b0;
      count   <= 4'd0;
      pend    <= 64'd0;
      pend_wr <= 1'b0;
    end else if (busy) begin
      if (count == 4'd1) begin
        busy    <= 1'b0;
        pend_wr <= 1'b0;
        if (pend_wr) begin
          hi <= pend[63:32];
          lo <= pend[31:0];
        end
      end
      if (count != 4'd0) begin
        count <= count - 4'd1;
      end
    end else if (start) begin
      if (launch) begin
        busy    <= 1'b1;
        count   <= launch_n;
        pend    <= launch_res;
        pend_wr <= launch_wr;
      end else if (op == OP_MTHI) begin
        hi <= rs;
      end else if (op == OP_MTLO) begin
        lo <= rs;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed scoreboard bench for mdu_unit
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int failed = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs = a; rt = b;
    step();
    start = 1'b0; op = 4'd0;
  endtask

  task automatic wait_idle(inout int n);
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic compare_pop(input string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  // Long op: busy must last exactly ncyc cycles with HI held at the old value meanwhile.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc, input logic [63:0] exp);
    int n;
    sb.push_back(exp);
    issue(o, a, b);
    check({tag, "_hold_hi"}, hi, m_hi);
    n = 0;
    wait_idle(n);
    check({tag, "_cycles"}, n, ncyc);
    compare_pop(tag);
  endtask

  task automatic move_op(input string tag, input logic [3:0] o, input logic [31:0] a);
    if (o == 4'd5) sb.push_back({a, m_lo});
    else sb.push_back({m_hi, a});
    issue(o, a, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    compare_pop(tag);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    step();
    step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    issue(4'd1, 32'd3, 32'd5);
    check("abort_busy_on", {31'd0, busy}, 32'd1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) step();
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 5, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5, 64'h0000_0001_FFFF_FFFE);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu", 4'd4, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000);
    run_op("div_neg_den", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD);

    move_op("mthi", 4'd5, 32'h1234_5678);
    move_op("mtlo", 4'd6, 32'h9ABC_DEF0);
    run_op("div0", 4'd3, 32'd5, 32'd0, 10, 64'h1234_5678_9ABC_DEF0);

    sb.push_back(64'h0000_0000_0000_0006);
    issue(4'd1, 32'd2, 32'd3);
    step();
    issue(4'd4, 32'd100, 32'd7);
    n = 2;
    wait_idle(n);
    check("ignore_cycles", n, 5);
    compare_pop("ignore");
    for (int i = 0; i < 12; i++) step();
    check("ignore_late_busy", {31'd0, busy}, 32'd0);
    check("ignore_late_lo", lo, 32'd6);

    issue(4'd0, 32'hDEAD_BEEF, 32'd1);
    check("nop0_busy", {31'd0, busy}, 32'd0);
    issue(4'd12, 32'hDEAD_BEEF, 32'd1);
    check("nop12_busy", {31'd0, busy}, 32'd0);
    check("nop_hi", hi, m_hi);
    check("nop_lo", lo, m_lo);

    move_op("mthi0", 4'd5, 32'd0);
    move_op("mtlo1", 4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("madd", 4'd7, 32'd1, 32'd1, 5, 64'h0000_0001_0000_0000);
    run_op("msub", 4'd9, 32'd1, 32'd1, 5, 64'h0000_0000_FFFF_FFFF);
    run_op("maddu", 4'd8, 32'hFFFF_FFFF, 32'd2, 5, 64'h0000_0002_FFFF_FFFD);
`else
    sb.push_back({m_hi, m_lo});
    issue(4'd7, 32'd1, 32'd1);
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    compare_pop("madd_off");
    sb.push_back({m_hi, m_lo});
    issue(4'd9, 32'd1, 32'd1);
    check("msub_off_busy", {31'd0, busy}, 32'd0);
    compare_pop("msub_off");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
